// File: rtl/booth_mul_sched.sv
// booth_mul_sched: two requesters share one iterative radix-2 Booth signed
// multiplier. Round-robin arbitration in IDLE, one Booth step per clock in
// RUN, and the product is held in DONE until the consumer takes it.
// Optional feature macro: BOOTH_SCHED_CNT_EN adds the 8-bit op_count port,
// which counts completed response handshakes.
module booth_mul_sched #(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req0_valid,
    output logic               req0_ready,
    input  logic [WIDTH-1:0]   req0_x,
    input  logic [WIDTH-1:0]   req0_y,
    input  logic               req1_valid,
    output logic               req1_ready,
    input  logic [WIDTH-1:0]   req1_x,
    input  logic [WIDTH-1:0]   req1_y,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic               rsp_id,
    output logic [2*WIDTH-1:0] rsp_z,
    output logic               busy
`ifdef BOOTH_SCHED_CNT_EN
   ,output logic [7:0]         op_count
`endif
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;
    localparam int         CW     = $clog2(WIDTH + 1);

    logic [1:0]         state_q, state_d;
    logic [WIDTH:0]     a_q, a_d;
    logic [WIDTH:0]     m_q;
    logic [WIDTH-1:0]   q_q, q_d;
    logic               qm1_q, qm1_d;
    logic [CW-1:0]      cnt_q;
    logic               id_q;
    logic               last_q;
    logic               rsp_id_q;
    logic [2*WIDTH-1:0] rsp_z_q;

    logic               acc0, acc1, accept, last_step, rsp_hs;
    logic [WIDTH:0]     a_sum;
    logic [WIDTH-1:0]   sel_x, sel_y;

    // Arbitration: a lone requester wins; on a tie the one not granted last wins.
    assign req0_ready = (state_q == S_IDLE) & req0_valid & (~req1_valid | last_q);
    assign req1_ready = (state_q == S_IDLE) & req1_valid & (~req0_valid | ~last_q);
    assign acc0       = req0_ready;
    assign acc1       = req1_ready;
    assign accept     = acc0 | acc1;
    assign sel_x      = acc1 ? req1_x : req0_x;
    assign sel_y      = acc1 ? req1_y : req0_y;
    assign last_step  = (cnt_q == CW'(WIDTH - 1));
    assign rsp_hs     = (state_q == S_DONE) & rsp_ready;

    assign rsp_valid  = (state_q == S_DONE);
    assign busy       = (state_q != S_IDLE);
    assign rsp_id     = rsp_id_q;
    assign rsp_z      = rsp_z_q;

    // One Booth step: add/subtract M by the recoded bit pair, then arithmetic
    // shift of {A,Q,q-1}. A carries one guard bit so -2^(W-1) operands are exact.
    always_comb begin
        a_sum = a_q;
        case ({q_q[0], qm1_q})
            2'b10:   a_sum = a_q - m_q;
            2'b01:   a_sum = a_q + m_q;
            default: a_sum = a_q;
        endcase
        a_d   = {a_sum[WIDTH], a_sum[WIDTH:1]};
        q_d   = {a_sum[0], q_q[WIDTH-1:1]};
        qm1_d = q_q[0];
    end

    // Control FSM next state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept) state_d = S_RUN;
            S_RUN:   if (last_step) state_d = S_DONE;
            S_DONE:  if (rsp_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State, datapath and response registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            m_q      <= '0;
            q_q      <= '0;
            qm1_q    <= 1'b0;
            cnt_q    <= '0;
            id_q     <= 1'b0;
            last_q   <= 1'b1;
            rsp_id_q <= 1'b0;
            rsp_z_q  <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_IDLE && accept) begin
                a_q    <= '0;
                m_q    <= {sel_y[WIDTH-1], sel_y};
                q_q    <= sel_x;
                qm1_q  <= 1'b0;
                cnt_q  <= '0;
                id_q   <= acc1;
                last_q <= acc1;
            end else if (state_q == S_RUN) begin
                a_q   <= a_d;
                q_q   <= q_d;
                qm1_q <= qm1_d;
                cnt_q <= cnt_q + 1'b1;
                // Capture the result separately so it survives the next RUN.
                if (last_step) begin
                    rsp_z_q  <= {a_d[WIDTH-1:0], q_d};
                    rsp_id_q <= id_q;
                end
            end
        end
    end

`ifdef BOOTH_SCHED_CNT_EN
    logic [7:0] op_cnt_q;
    assign op_count = op_cnt_q;

    // Completed-response counter, wraps naturally at 8 bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) op_cnt_q <= '0;
        else if (rsp_hs) op_cnt_q <= op_cnt_q + 8'd1;
    end
`else
    logic unused_hs;
    assign unused_hs = rsp_hs;
`endif

endmodule

// File: tb/tb_booth_mul_sched.sv
// Directed self-checking bench for booth_mul_sched (WIDTH=4).
module tb_booth_mul_sched;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         req0_valid = 1'b0, req1_valid = 1'b0;
    logic         req0_ready, req1_ready;
    logic [W-1:0] req0_x = '0, req0_y = '0, req1_x = '0, req1_y = '0;
    logic         rsp_valid, rsp_id, busy;
    logic         rsp_ready = 1'b1;
    logic [2*W-1:0] rsp_z;
`ifdef BOOTH_SCHED_CNT_EN
    logic [7:0]   op_count;
`endif

    int pass_cnt = 0;
    int tot_cnt  = 0;

    always #5 clk = ~clk;

    booth_mul_sched #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_x(req0_x), .req0_y(req0_y),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_x(req1_x), .req1_y(req1_y),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_z(rsp_z),
        .busy(busy)
`ifdef BOOTH_SCHED_CNT_EN
       ,.op_count(op_count)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tot_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; #3; rst_n = 1'b1; #1;
    endtask

    // Wait for rsp_valid; returns the number of edges waited (bounded).
    task automatic wait_rsp(output int lat);
        lat = 0;
        while (!rsp_valid && lat < 20) begin tick(); lat++; end
    endtask

    // Issue one op from requester n, check latency/result, complete handshake.
    task automatic run_one(input string tag, input int n, input logic [W-1:0] x,
                           input logic [W-1:0] y, input logic [7:0] expz);
        int lat;
        if (n == 0) begin req0_x = x; req0_y = y; req0_valid = 1'b1; end
        else        begin req1_x = x; req1_y = y; req1_valid = 1'b1; end
        #1;
        chk({tag, "_ready"}, (n == 0) ? req0_ready : req1_ready, 1);
        tick();
        req0_valid = 1'b0; req1_valid = 1'b0;
        chk({tag, "_busy"}, busy, 1);
        wait_rsp(lat);
        chk({tag, "_lat"}, lat, 4);
        chk({tag, "_z"}, rsp_z, expz);
        chk({tag, "_id"}, rsp_id, n);
        rsp_ready = 1'b1;
        tick();
        chk({tag, "_vld_clr"}, rsp_valid, 0);
    endtask

    initial begin
        int lat;
        logic [7:0] z_keep;
        logic [7:0] exp_z [2];
        exp_z[0] = 8'h06;  // 2*3
        exp_z[1] = 8'hF1;  // -3*5

        #2;
        chk("rst_vld", rsp_valid, 0);
        chk("rst_z", rsp_z, 0);
        chk("rst_id", rsp_id, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rdy", {req0_ready, req1_ready}, 0);
        rst_n = 1'b1;
        tick();

        run_one("r0_3x5", 0, 4'd3, 4'd5, 8'h0F);
        run_one("r1_m8xm8", 1, 4'h8, 4'h8, 8'h40);
        run_one("r1_7xm8", 1, 4'd7, 4'h8, 8'hC8);
        run_one("r0_m8x7", 0, 4'h8, 4'd7, 8'hC8);

        // Both requesters continuously valid: grants alternate 0,1,0,1.
        do_reset();
        req0_x = 4'd2; req0_y = 4'd3; req1_x = 4'hD; req1_y = 4'd5;
        req0_valid = 1'b1; req1_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk($sformatf("alt%0d_rdy", i), {req1_ready, req0_ready}, (i % 2) ? 2'b10 : 2'b01);
            tick();
            wait_rsp(lat);
            chk($sformatf("alt%0d_id", i), rsp_id, i % 2);
            chk($sformatf("alt%0d_z", i), rsp_z, exp_z[i % 2]);
            tick();
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        tick();

        // Stall in DONE with rsp_ready low; a waiting requester must not be accepted.
        rsp_ready = 1'b0;
        req0_x = 4'd5; req0_y = 4'hD; req0_valid = 1'b1;  // 5*-3 = -15
        tick();
        req0_valid = 1'b0;
        wait_rsp(lat);
        z_keep = rsp_z;
        chk("stall_z0", rsp_z, 8'hF1);
        req1_x = 4'd1; req1_y = 4'd1; req1_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("stall%0d", i), {rsp_valid, rsp_id, rsp_z, req0_ready, req1_ready},
                {1'b1, 1'b0, z_keep, 2'b00});
        end
        rsp_ready = 1'b1;
        tick();
        chk("resume_rdy", {rsp_valid, req1_ready}, 2'b01);
        tick();
        req1_valid = 1'b0;
        wait_rsp(lat);
        chk("resume_z", {rsp_id, rsp_z}, {1'b1, 8'h01});
        tick();

        // Reset pulse during RUN aborts the operation.
        req0_x = 4'd3; req0_y = 4'd3; req0_valid = 1'b1;
        tick();
        req0_valid = 1'b0;
        tick(); tick();
        rst_n = 1'b0; #2;
        chk("abort_out", {rsp_valid, busy, req0_ready, req1_ready}, 0);
        rst_n = 1'b1;
        tick();
        lat = 0;
        for (int i = 0; i < 6; i++) begin tick(); lat += rsp_valid; end
        chk("abort_norsp", lat, 0);
        run_one("post_rst", 0, 4'hF, 4'd1, 8'hFF);

`ifdef BOOTH_SCHED_CNT_EN
        do_reset();
        chk("cnt_rst", op_count, 0);
        for (int i = 0; i < 257; i++) begin
            req0_x = 4'd1; req0_y = 4'd1; req0_valid = 1'b1;
            tick();
            req0_valid = 1'b0;
            wait_rsp(lat);
            tick();
        end
        chk("cnt_wrap", op_count, 1);
`endif

        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule

// File: doc/booth_mul_sched.md
# booth_mul_sched

Two-port scheduler that shares a single iterative radix-2 Booth signed multiplier between two requesters. It round-robin arbitrates incoming operand pairs, sequences one Booth recoding step per clock, and returns the 2·WIDTH-bit product tagged with the requester ID over a valid/ready response channel. It sits between the pin-level operand capture logic and the result output mux of the multiplier tile.

## Interface
- WIDTH, default 4, operand width in bits (signed two's complement); product is 2·WIDTH bits.
- clk  input  1  clock, all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req0_valid  input  1  requester 0 has an operand pair.
- req0_ready  output  1  requester 0 pair accepted this cycle when valid & ready.
- req0_x, req0_y  input  WIDTH each  requester 0 multiplier / multiplicand.
- req1_valid, req1_ready, req1_x, req1_y  same as requester 0, for requester 1.
- rsp_valid  output  1  product available.
- rsp_ready  input  1  consumer accepts product.
- rsp_id  output  1  requester that issued the product (0 or 1).
- rsp_z  output  2·WIDTH  signed product x·y.
- busy  output  1  high in RUN or DONE.
- op_count  output  8  completed-response counter (only with BOOTH_SCHED_CNT_EN).

## Operation
- States: IDLE, RUN, DONE. Reset: IDLE, rsp_valid=0, rsp_id=0, rsp_z=0, busy=0, req*_ready=0, last_grant=1, op_count=0.
- IDLE: grant = requester with valid; both valid -> the one not equal to last_grant. reqN_ready = (state==IDLE) & grant==N, combinational; never both high.
- Accept (valid & ready): latch M=y (sign-extended to WIDTH+1), Q=x, q_-1=0, A=0 (WIDTH+1 bits), id=N, last_grant=N, iteration counter=0; go RUN.
- RUN, each cycle: {Q[0],q_-1}=10 -> A=A−M; 01 -> A=A+M; 00/11 -> no op. Then arithmetic shift right of {A,Q,q_-1} by one. After WIDTH iterations go DONE.
- DONE: rsp_valid=1, rsp_z={A[WIDTH-1:0],Q}, rsp_id=id; outputs held stable until rsp_valid & rsp_ready, then rsp_valid=0, go IDLE.
- Operands are sampled only at acceptance; later changes on req*_x/y are ignored. Requesters keep valid and operands stable until ready; the block does not check this.
- Full signed range is exact, including (−2^(WIDTH−1))·(−2^(WIDTH−1)).
- rsp_z and rsp_id retain the last product after handshake; only rsp_valid qualifies them.
- rst_n low in any state: aborts operation immediately, no response issued, all outputs to reset values.

## Timing
- Acceptance edge k; RUN occupies edges k+1..k+WIDTH; rsp_valid high from the cycle after edge k+WIDTH (WIDTH cycles after acceptance).
- Response handshake at edge r -> IDLE from r+1; next acceptance no earlier than edge r+1. Minimum period per operation WIDTH+2 cycles.
- rsp_ready low stalls indefinitely in DONE; req*_ready stays low throughout.
- No combinational path from rsp_ready to any output; req*_ready depends only on state, req*_valid and last_grant.

## Configuration
- BOOTH_SCHED_CNT_EN defined: op_count increments by 1 (wraps 255->0) on every response handshake; reset 0.
- Undefined: op_count port absent, no counter logic.

## Test plan
- req0 x=3,y=5 -> req0_ready high same cycle, rsp_valid 4 cycles later, rsp_z=0x0F, rsp_id=0.
- req1 x=−8,y=−8 -> rsp_z=0x40, rsp_id=1; x=7,y=−8 -> rsp_z=0xC8.
- Both valid continuously after reset -> grants alternate 0,1,0,1; four products correct and ids match.
- rsp_ready low 5 cycles in DONE -> rsp_valid, rsp_z, rsp_id stable, both req*_ready low; accept resumes the cycle after handshake.
- rst_n pulsed low during RUN -> no rsp_valid, busy=0, next request (x=−1,y=1) yields 0xFF.
- With BOOTH_SCHED_CNT_EN: 257 responses -> op_count=1.
